par_serializer: RTL
===================

PAR_SERIALIZER -- requirements
Module: par_serializer

Interface
REQ-001 Parameter WIDTH, default 8, parallel word width in bits; legal range 2..64.
REQ-002 Parameter LSB_FIRST, default 0; 0 = MSB shifted out first, 1 = LSB first.
REQ-003 Parameter IDLE_LEVEL, default 1'b0, SERIAL_OUT level when no word is being shifted.
REQ-004 CLK  input  1  single clock; all state changes on rising edge.
REQ-005 RESET  input  1  asynchronous, active-low reset.
REQ-006 PAR_IN  input  WIDTH  parallel word, sampled on an accepting edge.
REQ-007 IN_VALID  input  1  PAR_IN holds a word to transfer.
REQ-008 IN_READY  output  1  block accepts a word on this edge if IN_VALID=1.
REQ-009 SERIAL_OUT  output  1  registered serial data, one bit per CLK cycle.
REQ-010 SERIAL_VALID  output  1  SERIAL_OUT carries a data bit this cycle.
REQ-011 FRAME_START  output  1  high during the cycle carrying bit 0 of the shift order (first bit of a word).
REQ-012 FRAME_END  output  1  high during the cycle carrying the last bit of a word.

Function
REQ-013 The block SHALL implement states IDLE and SHIFT, plus a WIDTH-bit shift register and a bit counter of $clog2(WIDTH) bits.
REQ-014 A word is accepted on a rising edge where IN_VALID=1 and IN_READY=1; PAR_IN is loaded into the shift register on that edge.
REQ-015 IN_READY SHALL be 1 in IDLE, and 1 in SHIFT only while the counter equals WIDTH-1; 0 otherwise (combinational from state and counter).
REQ-016 IDLE -> SHIFT on acceptance; counter set to 0; first bit appears on SERIAL_OUT in the cycle after the accepting edge (latency 1).
REQ-017 In SHIFT the counter increments by 1 per edge; bit order per LSB_FIRST.
REQ-018 At counter=WIDTH-1 with acceptance: stay in SHIFT, counter to 0, new word loaded; back-to-back words SHALL stream with zero idle cycles.
REQ-019 At counter=WIDTH-1 without acceptance: SHIFT -> IDLE; SERIAL_OUT returns to IDLE_LEVEL, SERIAL_VALID to 0, on the next cycle.
REQ-020 SERIAL_VALID SHALL be 1 exactly while in SHIFT; FRAME_START SHALL be 1 when SHIFT and counter=0; FRAME_END when SHIFT and counter=WIDTH-1.
REQ-021 IN_VALID while IN_READY=0 SHALL have no effect; PAR_IN changes while not accepted are ignored.
REQ-022 All outputs except IN_READY SHALL be driven from flops; no latches and no clock-gated output muxing.
REQ-023 Exactly WIDTH SERIAL_VALID cycles SHALL be produced per accepted word; no bit dropped or duplicated.

Reset
REQ-024 RESET=0 SHALL immediately force: state IDLE, counter 0, shift register 0, SERIAL_OUT=IDLE_LEVEL, SERIAL_VALID=0, FRAME_START=0, FRAME_END=0, IN_READY=1.
REQ-025 Reset during SHIFT SHALL discard the partial word; no remaining bits emitted after release.
REQ-026 First acceptance possible on the first rising edge after RESET deasserts.

Structure
REQ-027 Shared package ser_pkg SHALL hold the state typedef (IDLE, SHIFT) and the counter-width function; par_serializer imports it.
REQ-028 Single module; no sub-module required (shift register and counter inline).

Verification
REQ-029 WIDTH=8, LSB_FIRST=0: accept 8'hA5 once -> SERIAL_OUT 1,0,1,0,0,1,0,1 over 8 cycles starting 1 cycle after accept; FRAME_START on bit 1, FRAME_END on bit 8; then IDLE_LEVEL, SERIAL_VALID=0.
REQ-030 LSB_FIRST=1, accept 8'hA5 -> 1,0,1,0,0,1,0,1 reversed: 1,0,1,0,0,1,0,1 read LSB-first = 1,0,1,0,0,1,0,1; bench checks against bit-reversed model and also 8'h01 -> 1,0,0,0,0,0,0,0.
REQ-031 Continuous IN_VALID with 8'hFF then 8'h00 -> 16 consecutive SERIAL_VALID cycles, 8 ones then 8 zeros, IN_READY pulsing only on cycles with FRAME_END.
REQ-032 IN_VALID held high with changing PAR_IN mid-word -> only words present on READY edges serialized; intermediate values never appear.
REQ-033 RESET asserted after 3 bits of 8'hC3 -> outputs reset asynchronously; after release SERIAL_VALID=0 until next acceptance; no remaining bits of 8'hC3 appear.
REQ-034 WIDTH=2 stream 2'b10,2'b01 -> SERIAL_OUT 1,0,0,1 with FRAME_START and FRAME_END alternating each cycle.

Source files
------------

// File: rtl/ser_pkg.sv
// Shared types and helpers for the parallel-to-serial converter.
package ser_pkg;

   // Two-state controller: waiting for a word, or shifting one out.
   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_t;

   // Bit-counter width for a given word width; never narrower than one bit
   // so that WIDTH=2 still gets a usable counter.
   function automatic int cnt_width(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/par_serializer.sv
// Parallel-in, serial-out converter with valid/ready intake and
// frame-start/frame-end markers. Back-to-back words stream with no gap.
module par_serializer
   import ser_pkg::*;
#(
   parameter int   WIDTH      = 8,
   parameter bit   LSB_FIRST  = 1'b0,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] par_in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             serial_out,
   output logic             serial_valid,
   output logic             frame_start,
   output logic             frame_end
);

   localparam int             CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   ser_state_t       state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [WIDTH-1:0] shift_reg;
   logic             serial_out_reg;
   logic             serial_valid_reg;
   logic             frame_start_reg;
   logic             frame_end_reg;

   // The shift register holds the bits still waiting to go out, so the first
   // bit of a new word goes straight into the output flop and the remainder
   // is loaded already advanced by one position.
   logic             load_bit;
   logic [WIDTH-1:0] load_rest;
   logic             next_bit;
   logic [WIDTH-1:0] next_rest;
   logic             accept;

   generate
      if (LSB_FIRST) begin : g_lsb_first
         assign load_bit  = par_in[0];
         assign load_rest = {1'b0, par_in[WIDTH-1:1]};
         assign next_bit  = shift_reg[0];
         assign next_rest = {1'b0, shift_reg[WIDTH-1:1]};
      end else begin : g_msb_first
         assign load_bit  = par_in[WIDTH-1];
         assign load_rest = {par_in[WIDTH-2:0], 1'b0};
         assign next_bit  = shift_reg[WIDTH-1];
         assign next_rest = {shift_reg[WIDTH-2:0], 1'b0};
      end
   endgenerate

   // Ready when idle, or during the last bit so the next word follows seamlessly.
   assign in_ready = (state_reg == IDLE) || (cnt_reg == CNT_LAST);
   assign accept   = in_valid && in_ready;

   // Controller, counter, shift register and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg        <= IDLE;
         cnt_reg          <= '0;
         shift_reg        <= '0;
         serial_out_reg   <= IDLE_LEVEL;
         serial_valid_reg <= 1'b0;
         frame_start_reg  <= 1'b0;
         frame_end_reg    <= 1'b0;
      end else if (accept) begin
         state_reg        <= SHIFT;
         cnt_reg          <= '0;
         shift_reg        <= load_rest;
         serial_out_reg   <= load_bit;
         serial_valid_reg <= 1'b1;
         frame_start_reg  <= 1'b1;
         frame_end_reg    <= 1'b0;
      end else if ((state_reg == SHIFT) && (cnt_reg != CNT_LAST)) begin
         cnt_reg          <= cnt_reg + 1'b1;
         shift_reg        <= next_rest;
         serial_out_reg   <= next_bit;
         serial_valid_reg <= 1'b1;
         frame_start_reg  <= 1'b0;
         frame_end_reg    <= ((cnt_reg + 1'b1) == CNT_LAST);
      end else begin
         state_reg        <= IDLE;
         cnt_reg          <= '0;
         shift_reg        <= '0;
         serial_out_reg   <= IDLE_LEVEL;
         serial_valid_reg <= 1'b0;
         frame_start_reg  <= 1'b0;
         frame_end_reg    <= 1'b0;
      end
   end

   assign serial_out   = serial_out_reg;
   assign serial_valid = serial_valid_reg;
   assign frame_start  = frame_start_reg;
   assign frame_end    = frame_end_reg;

endmodule
